dds_ctrl: RTL and testbench
===========================

DDS_CTRL -- requirements
Module: dds_ctrl

Interface
REQ-001 Parameter FW_MIN, default 32'd85_899, minimum frequency tuning word (1 kHz at 50 MHz, 32-bit accumulator).
REQ-002 Parameter FW_MAX, default 32'd85_899_346, maximum frequency tuning word (1 MHz).
REQ-003 Parameter FW_STEP, default 32'd85_899, frequency increment per key press or sweep tick.
REQ-004 Parameter PH_STEP, default 12'd256, phase offset increment per key press.
REQ-005 Parameter SWEEP_DIV, default 20'd999_999, sweep tick period minus one, in sys_clk cycles.
REQ-006 sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-007 sys_rst  input  1  asynchronous, active-high reset.
REQ-008 key_flag  input  4  debounced single-cycle key pulses: [0] freq up, [1] freq down, [2] phase step, [3] mode cycle.
REQ-009 upd_ready  input  1  DDS core accepts the current parameter set.
REQ-010 freq_word  output  32  registered frequency tuning word presented to the DDS core.
REQ-011 phase_word  output  12  registered phase offset presented to the DDS core.
REQ-012 upd_valid  output  1  freq_word/phase_word hold a new, unaccepted parameter set.
REQ-013 mode  output  2  current state: 2'd0 MANUAL, 2'd1 SWEEP, 2'd2 HOLD.

Function
REQ-014 The block SHALL keep internal working registers fw_work (32 bits) and ph_work (12 bits), separate from the output shadows freq_word/phase_word.
REQ-015 The block SHALL process at most one key_flag bit per cycle, priority [3] > [0] > [1] > [2]; lower-priority simultaneous pulses are dropped.
REQ-016 FSM: key_flag[3] SHALL move MANUAL->SWEEP->HOLD->MANUAL; mode value 2'd3 is unreachable and SHALL return to MANUAL on the next cycle.
REQ-017 In MANUAL and HOLD, key_flag[0] SHALL set fw_work = min(fw_work+FW_STEP, FW_MAX), computed without 32-bit overflow.
REQ-018 In MANUAL and HOLD, key_flag[1] SHALL set fw_work = max(fw_work-FW_STEP, FW_MIN), computed without underflow.
REQ-019 In all states, key_flag[2] SHALL set ph_work = (ph_work+PH_STEP) mod 4096.
REQ-020 In SWEEP, key_flag[0] and key_flag[1] SHALL be ignored.
REQ-021 On entry to SWEEP, the sweep counter SHALL clear to 0 and the sweep direction SHALL be set to up.
REQ-022 In SWEEP, the counter SHALL count 0..SWEEP_DIV; on the cycle the counter equals SWEEP_DIV it SHALL wrap to 0 and step fw_work by FW_STEP in the current direction, saturating as in REQ-017/018.
REQ-023 On a sweep tick in which fw_work reaches FW_MAX, the direction SHALL flip to down; on reaching FW_MIN, it SHALL flip to up.
REQ-024 In HOLD and MANUAL, the sweep counter SHALL hold at 0.
REQ-025 Handshake: when upd_valid=0 and (fw_work,ph_work) differs from (freq_word,phase_word), the block SHALL copy fw_work/ph_work into the shadows and assert upd_valid on the next cycle.
REQ-026 While upd_valid=1, freq_word and phase_word SHALL remain stable; upd_valid SHALL deassert the cycle after upd_valid&&upd_ready is sampled.
REQ-027 Working-register changes during a pending handshake SHALL be retained; only the latest values are loaded when the handshake is next idle, with no intermediate values queued.
REQ-028 upd_ready asserted while upd_valid=0 SHALL have no effect.

Reset
REQ-029 While sys_rst=1, the block SHALL force fw_work=freq_word=FW_MIN, ph_work=phase_word=0, upd_valid=0, mode=MANUAL, counter=0, direction=up.
REQ-030 Reset asserted mid-handshake or mid-sweep SHALL abort the operation immediately with no further upd_valid pulse.
REQ-031 After reset release, the first upd_valid SHALL occur only after a working-register change.

Verification
REQ-032 Reset, then pulse key_flag[0] with upd_ready=1 -> upd_valid high one cycle later with freq_word=171_798, then low one cycle after that.
REQ-033 Hold upd_ready=0 and pulse key_flag[0] three times -> freq_word stays 171_798 with upd_valid high; raise upd_ready -> upd_valid low, then a new handshake presents freq_word=343_596 (fw_work after three steps; no intermediate values).
REQ-034 Press key_flag[1] at FW_MIN -> no change and no upd_valid; step up 1000 times -> freq_word saturates at 85_899_346.
REQ-035 Press key_flag[2] 17 times -> phase_word = 256 (wrap-around).
REQ-036 With SWEEP_DIV=3, enter SWEEP -> fw_work steps every 4 cycles, flips direction at FW_MAX/FW_MIN, ignores key_flag[0]; pulse key_flag[3] -> HOLD freezes fw_work.
REQ-037 Pulse key_flag[3] and key_flag[0] in the same cycle in MANUAL -> mode=SWEEP and fw_work unchanged.

Source files
------------

// File: rtl/dds_ctrl.sv
// dds_ctrl: key-driven frequency/phase controller for a DDS core.
// Keeps working registers for the tuning word and phase offset. In SWEEP
// mode a divider ticks the tuning word between FW_MIN and FW_MAX. Parameter
// sets reach the core through shadow registers and a valid/ready handshake.
module dds_ctrl #(
    parameter logic [31:0] FW_MIN    = 32'd85_899,
    parameter logic [31:0] FW_MAX    = 32'd85_899_346,
    parameter logic [31:0] FW_STEP   = 32'd85_899,
    parameter logic [11:0] PH_STEP   = 12'd256,
    parameter logic [19:0] SWEEP_DIV = 20'd999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  key_flag,
    input  logic        upd_ready,
    output logic [31:0] freq_word,
    output logic [11:0] phase_word,
    output logic        upd_valid,
    output logic [1:0]  mode
);

    localparam logic [1:0] ST_MANUAL = 2'd0;
    localparam logic [1:0] ST_SWEEP  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // Saturating increment; the sum is formed in 33 bits so it cannot wrap.
    function automatic logic [31:0] sat_inc(input logic [31:0] fw);
        logic [32:0] sum_v;
        sum_v = {1'b0, fw} + {1'b0, FW_STEP};
        if (sum_v > {1'b0, FW_MAX}) begin
            sat_inc = FW_MAX;
        end else begin
            sat_inc = sum_v[31:0];
        end
    endfunction

    // Saturating decrement; a set bit 32 flags a borrow past zero.
    function automatic logic [31:0] sat_dec(input logic [31:0] fw);
        logic [32:0] diff_v;
        diff_v = {1'b0, fw} - {1'b0, FW_STEP};
        if (diff_v[32] || (diff_v[31:0] < FW_MIN)) begin
            sat_dec = FW_MIN;
        end else begin
            sat_dec = diff_v[31:0];
        end
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [31:0] fw_work_r;
    logic [31:0] fw_nxt_s;
    logic [11:0] ph_work_r;
    logic [11:0] ph_nxt_s;
    logic [19:0] sweep_cnt_r;
    logic [19:0] cnt_nxt_s;
    logic        dir_up_r;
    logic        dir_up_nxt_s;
    logic [31:0] freq_word_r;
    logic [11:0] phase_word_r;
    logic        upd_valid_r;
    logic [31:0] fw_inc_s;
    logic [31:0] fw_dec_s;
    logic        key_mode_s;
    logic        key_up_s;
    logic        key_dn_s;
    logic        key_ph_s;
    logic        sweep_wrap_s;
    logic        shadow_diff_s;

    // Only the highest-priority key is acted on: [3] > [0] > [1] > [2].
    assign key_mode_s = key_flag[3];
    assign key_up_s   = key_flag[0] & ~key_flag[3];
    assign key_dn_s   = key_flag[1] & ~key_flag[3] & ~key_flag[0];
    assign key_ph_s   = key_flag[2] & ~key_flag[3] & ~key_flag[0] & ~key_flag[1];

    assign fw_inc_s      = sat_inc(fw_work_r);
    assign fw_dec_s      = sat_dec(fw_work_r);
    assign sweep_wrap_s  = (sweep_cnt_r == SWEEP_DIV);
    assign shadow_diff_s = (fw_work_r != freq_word_r) || (ph_work_r != phase_word_r);

    assign freq_word  = freq_word_r;
    assign phase_word = phase_word_r;
    assign upd_valid  = upd_valid_r;
    assign mode       = state_r;

    // Mode state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= ST_MANUAL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Mode sequencing: the mode key cycles MANUAL -> SWEEP -> HOLD -> MANUAL.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_MANUAL: begin
                if (key_mode_s) state_nxt_s = ST_SWEEP;
                else            state_nxt_s = ST_MANUAL;
            end
            ST_SWEEP: begin
                if (key_mode_s) state_nxt_s = ST_HOLD;
                else            state_nxt_s = ST_SWEEP;
            end
            ST_HOLD: begin
                if (key_mode_s) state_nxt_s = ST_MANUAL;
                else            state_nxt_s = ST_HOLD;
            end
            default: state_nxt_s = ST_MANUAL;
        endcase
    end

    // Per-mode next values for the working registers, sweep counter and direction.
    always_comb begin
        fw_nxt_s     = fw_work_r;
        ph_nxt_s     = ph_work_r;
        cnt_nxt_s    = 20'd0;
        dir_up_nxt_s = dir_up_r;
        if (key_ph_s) ph_nxt_s = ph_work_r + PH_STEP;
        else          ph_nxt_s = ph_work_r;
        case (state_r)
            ST_MANUAL, ST_HOLD: begin
                if (key_up_s)      fw_nxt_s = fw_inc_s;
                else if (key_dn_s) fw_nxt_s = fw_dec_s;
                else               fw_nxt_s = fw_work_r;
                cnt_nxt_s = 20'd0;
                // Entering SWEEP always starts the ramp upwards.
                if ((state_r == ST_MANUAL) && key_mode_s) dir_up_nxt_s = 1'b1;
                else                                      dir_up_nxt_s = dir_up_r;
            end
            ST_SWEEP: begin
                if (sweep_wrap_s) begin
                    if (dir_up_r) begin
                        fw_nxt_s = fw_inc_s;
                        if (fw_inc_s == FW_MAX) dir_up_nxt_s = 1'b0;
                        else                    dir_up_nxt_s = dir_up_r;
                    end else begin
                        fw_nxt_s = fw_dec_s;
                        if (fw_dec_s == FW_MIN) dir_up_nxt_s = 1'b1;
                        else                    dir_up_nxt_s = dir_up_r;
                    end
                end else begin
                    fw_nxt_s     = fw_work_r;
                    dir_up_nxt_s = dir_up_r;
                end
                if (key_mode_s || sweep_wrap_s) cnt_nxt_s = 20'd0;
                else                            cnt_nxt_s = sweep_cnt_r + 20'd1;
            end
            default: begin
                fw_nxt_s     = fw_work_r;
                cnt_nxt_s    = 20'd0;
                dir_up_nxt_s = 1'b1;
            end
        endcase
    end

    // Working registers, sweep counter and sweep direction.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fw_work_r   <= FW_MIN;
            ph_work_r   <= 12'd0;
            sweep_cnt_r <= 20'd0;
            dir_up_r    <= 1'b1;
        end else begin
            fw_work_r   <= fw_nxt_s;
            ph_work_r   <= ph_nxt_s;
            sweep_cnt_r <= cnt_nxt_s;
            dir_up_r    <= dir_up_nxt_s;
        end
    end

    // Shadow handshake: load the latest working values only while idle and hold them until accepted.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            freq_word_r  <= FW_MIN;
            phase_word_r <= 12'd0;
            upd_valid_r  <= 1'b0;
        end else if (upd_valid_r) begin
            if (upd_ready) upd_valid_r <= 1'b0;
            else           upd_valid_r <= 1'b1;
        end else if (shadow_diff_s) begin
            freq_word_r  <= fw_work_r;
            phase_word_r <= ph_work_r;
            upd_valid_r  <= 1'b1;
        end else begin
            upd_valid_r  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dds_ctrl.sv
// tb_dds_ctrl: table-driven vectors, directed corner sequences and a
// randomized run checked against a cycle-level behavioural model.
module tb_dds_ctrl;

    localparam longint FW_MIN  = 85899;
    localparam longint FW_MAX  = 85899346;
    localparam longint FW_STEP = 85899;
    localparam int     PH_STEP = 256;
    localparam int     DIV     = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  key_flag = 4'd0;
    logic        upd_ready = 1'b0;
    logic [31:0] freq_word;
    logic [11:0] phase_word;
    logic        upd_valid;
    logic [1:0]  mode;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    longint m_fw, m_sfw;
    int     m_ph, m_sph, m_mode, m_cnt;
    bit     m_up, m_valid;

    typedef struct {
        logic [3:0] key;
        logic       rdy;
        longint     fw;
        int         ph;
        logic       v;
        int         md;
    } vec_t;
    vec_t tbl[20];

    dds_ctrl #(.SWEEP_DIV(20'd3)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_flag   (key_flag),
        .upd_ready  (upd_ready),
        .freq_word  (freq_word),
        .phase_word (phase_word),
        .upd_valid  (upd_valid),
        .mode       (mode)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint f_up(input longint v);
        return (v + FW_STEP > FW_MAX) ? FW_MAX : v + FW_STEP;
    endfunction

    function automatic longint f_dn(input longint v);
        return (v - FW_STEP < FW_MIN) ? FW_MIN : v - FW_STEP;
    endfunction

    task automatic model_reset();
        m_fw = FW_MIN; m_sfw = FW_MIN; m_ph = 0; m_sph = 0;
        m_mode = 0; m_cnt = 0; m_up = 1'b1; m_valid = 1'b0;
    endtask

    // One clock of the controller, described from its rules.
    task automatic model_step(input logic [3:0] k, input bit rdy);
        int sel;
        if (k[3])      sel = 3;
        else if (k[0]) sel = 0;
        else if (k[1]) sel = 1;
        else if (k[2]) sel = 2;
        else           sel = -1;
        if (m_valid) begin
            if (rdy) m_valid = 1'b0;
        end else if (m_fw != m_sfw || m_ph != m_sph) begin
            m_sfw = m_fw; m_sph = m_ph; m_valid = 1'b1;
        end
        if (m_mode == 1) begin
            if (m_cnt == DIV) begin
                m_cnt = 0;
                if (m_up) begin
                    m_fw = f_up(m_fw);
                    if (m_fw == FW_MAX) m_up = 1'b0;
                end else begin
                    m_fw = f_dn(m_fw);
                    if (m_fw == FW_MIN) m_up = 1'b1;
                end
            end else begin
                m_cnt++;
            end
        end else if (sel == 0) begin
            m_fw = f_up(m_fw);
        end else if (sel == 1) begin
            m_fw = f_dn(m_fw);
        end
        if (sel == 2) m_ph = (m_ph + PH_STEP) % 4096;
        if (sel == 3) begin
            m_mode = (m_mode + 1) % 3;
            m_cnt = 0;
            if (m_mode == 1) m_up = 1'b1;
        end
    endtask

    task automatic cyc(input logic [3:0] k, input bit rdy);
        key_flag  = k;
        upd_ready = rdy;
        @(posedge sys_clk);
        model_step(k, rdy);
        #1;
        key_flag = 4'd0;
    endtask

    task automatic check_model(input string tag);
        check({tag, " freq_word"}, freq_word, m_sfw);
        check({tag, " phase_word"}, phase_word, m_sph);
        check({tag, " upd_valid"}, upd_valid, m_valid);
        check({tag, " mode"}, mode, m_mode);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        key_flag = 4'd0;
        upd_ready = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        model_reset();
        check_model("reset");
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        bit saw_max, saw_min_again;
        tbl[0]  = '{4'b0001, 1'b1, 85899,  0,   1'b0, 0};
        tbl[1]  = '{4'b0000, 1'b1, 171798, 0,   1'b1, 0};
        tbl[2]  = '{4'b0000, 1'b1, 171798, 0,   1'b0, 0};
        tbl[3]  = '{4'b0100, 1'b0, 171798, 0,   1'b0, 0};
        tbl[4]  = '{4'b0000, 1'b0, 171798, 256, 1'b1, 0};
        tbl[5]  = '{4'b0001, 1'b0, 171798, 256, 1'b1, 0};
        tbl[6]  = '{4'b0000, 1'b1, 171798, 256, 1'b0, 0};
        tbl[7]  = '{4'b0000, 1'b0, 257697, 256, 1'b1, 0};
        tbl[8]  = '{4'b0010, 1'b1, 257697, 256, 1'b0, 0};
        tbl[9]  = '{4'b0000, 1'b0, 171798, 256, 1'b1, 0};
        tbl[10] = '{4'b1001, 1'b1, 171798, 256, 1'b0, 1};
        tbl[11] = '{4'b0000, 1'b1, 171798, 256, 1'b0, 1};
        tbl[12] = '{4'b1000, 1'b1, 171798, 256, 1'b0, 2};
        tbl[13] = '{4'b0001, 1'b1, 171798, 256, 1'b0, 2};
        tbl[14] = '{4'b0000, 1'b1, 257697, 256, 1'b1, 2};
        tbl[15] = '{4'b1000, 1'b1, 257697, 256, 1'b0, 0};
        tbl[16] = '{4'b0110, 1'b1, 257697, 256, 1'b0, 0};
        tbl[17] = '{4'b0000, 1'b1, 171798, 256, 1'b1, 0};
        tbl[18] = '{4'b0000, 1'b0, 171798, 256, 1'b1, 0};
        tbl[19] = '{4'b0000, 1'b1, 171798, 256, 1'b0, 0};

        // Table-driven vectors
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].key, tbl[i].rdy);
            check($sformatf("vec%0d freq_word", i), freq_word, tbl[i].fw);
            check($sformatf("vec%0d phase_word", i), phase_word, tbl[i].ph);
            check($sformatf("vec%0d upd_valid", i), upd_valid, tbl[i].v);
            check($sformatf("vec%0d mode", i), mode, tbl[i].md);
        end

        // Pending handshake keeps shadows; only the latest value is presented next
        do_reset();
        cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b0);
        check("pend first freq", freq_word, 171798);
        check("pend first valid", upd_valid, 1);
        cyc(4'b0001, 1'b0);
        cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b0);
        check("pend hold freq", freq_word, 171798);
        check("pend hold valid", upd_valid, 1);
        cyc(4'b0000, 1'b1);
        check("pend accept valid", upd_valid, 0);
        cyc(4'b0000, 1'b0);
        check("pend latest freq", freq_word, 343596);
        check("pend latest valid", upd_valid, 1);

        // Lower saturation, then saturate at the top
        do_reset();
        cyc(4'b0010, 1'b1);
        cyc(4'b0000, 1'b1);
        check("min sat freq", freq_word, FW_MIN);
        check("min sat valid", upd_valid, 0);
        for (int i = 0; i < 1000; i++) begin
            cyc(4'b0001, 1'b1);
            check_model("up run");
        end
        repeat (3) cyc(4'b0000, 1'b1);
        check("max sat freq", freq_word, 85899346);

        // Phase wrap
        do_reset();
        for (int i = 0; i < 17; i++) cyc(4'b0100, 1'b1);
        repeat (3) cyc(4'b0000, 1'b1);
        check("phase wrap", phase_word, 256);

        // Sweep up to the top and back down to the bottom, then HOLD
        do_reset();
        cyc(4'b1000, 1'b1);
        saw_max = 1'b0;
        saw_min_again = 1'b0;
        for (int i = 0; i < 8200; i++) begin
            cyc(($urandom_range(0, 49) == 0) ? 4'b0001 : 4'b0000, 1'b1);
            check_model("sweep");
            if (freq_word == 32'(FW_MAX)) saw_max = 1'b1;
            if (saw_max && freq_word == 32'(FW_MIN)) saw_min_again = 1'b1;
        end
        check("sweep reached max", saw_max, 1);
        check("sweep returned to min", saw_min_again, 1);
        cyc(4'b1000, 1'b1);
        check("hold mode", mode, 2);
        for (int i = 0; i < 20; i++) begin
            cyc(4'b0000, 1'b1);
            check_model("hold");
        end

        // Reset mid-handshake aborts it
        do_reset();
        cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b0);
        check("abort pre valid", upd_valid, 1);
        #2 sys_rst = 1'b1;
        #1;
        check("abort valid", upd_valid, 0);
        check("abort freq", freq_word, FW_MIN);
        model_reset();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0000, 1'b1);
            check_model("post abort");
        end

        // Reset mid-sweep returns to MANUAL
        cyc(4'b1000, 1'b1);
        repeat (10) cyc(4'b0000, 1'b1);
        #2 sys_rst = 1'b1;
        #1;
        check("sweep abort mode", mode, 0);
        model_reset();
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                1'($urandom_range(0, 1)));
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
